// File: rtl/seeg_ctrl_pkg.sv
// Shared definitions for the sEEG front-end ownership scheduler.
package seeg_ctrl_pkg;

  localparam int STATE_W               = 3;
  localparam int SETTLE_CYCLES_DEFAULT = 156;

  // Encodings are exposed on the status readback port, so keep them fixed.
  typedef enum logic [STATE_W-1:0] {
    S_IDLE       = 3'd0,
    S_ZCHECK     = 3'd1,
    S_REC_SETTLE = 3'd2,
    S_RECORD     = 3'd3,
    S_STIM       = 3'd4
  } state_t;

endpackage

// File: rtl/seeg_settle_counter.sv
// Loadable down-counter that times how long record_en is held before
// recording is considered established.
module seeg_settle_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             expired
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (dec) begin
      value <= value - 1'b1;
    end
  end

  assign expired = (value <= CNT_W'(1));

endmodule

// File: rtl/seeg_mode_scheduler.sv
// Grants the shared headstage link to record, impedance check or stimulation,
// one at a time, and enforces the ordering rules between them.
module seeg_mode_scheduler
  import seeg_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
  parameter int CNT_W         = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         record_start,
  input  logic         record_stop,
  input  logic         zcheck_start,
  input  logic         stim_finite_start,
  input  logic         stim_infinite_start,
  input  logic         stim_infinite_stop,
  input  logic         zcheck_done,
  input  logic         stim_done,
  output logic         record_en,
  output logic         zcheck_go,
  output logic         stim_finite_go,
  output logic         stim_infinite_go,
  output logic         stim_infinite_halt,
  output logic         reject,
  output logic         busy,
  output logic [2:0]   state
);

  // A zero settle time still spends one cycle in REC_SETTLE.
  localparam logic [CNT_W-1:0] SETTLE_LOAD =
    (SETTLE_CYCLES < 1) ? CNT_W'(1) : CNT_W'(SETTLE_CYCLES);

  state_t           state_q;
  logic             inf_q;
  logic             halt_sent_q;
  logic             stop_pend_q;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_value;
  logic             settle_expired;
  logic             stim_start_any;
  logic             any_start;
  logic             halt_now;

  assign stim_start_any = stim_finite_start | stim_infinite_start;
  assign any_start      = stim_start_any | record_start | zcheck_start;
  assign cnt_load       = (state_q == S_IDLE) && record_start && !zcheck_start;
  assign cnt_dec        = (state_q == S_REC_SETTLE) && (cnt_value != '0);
  assign halt_now       = inf_q && !halt_sent_q && (stim_infinite_stop || record_stop);
  assign state          = state_q;

  seeg_settle_counter #(.CNT_W(CNT_W)) u_settle (
    .clk        (clk),
    .rstn       (rstn),
    .load       (cnt_load),
    .load_value (SETTLE_LOAD),
    .dec        (cnt_dec),
    .value      (cnt_value),
    .expired    (settle_expired)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q            <= S_IDLE;
      record_en          <= 1'b0;
      zcheck_go          <= 1'b0;
      stim_finite_go     <= 1'b0;
      stim_infinite_go   <= 1'b0;
      stim_infinite_halt <= 1'b0;
      reject             <= 1'b0;
      busy               <= 1'b0;
      inf_q              <= 1'b0;
      halt_sent_q        <= 1'b0;
      stop_pend_q        <= 1'b0;
    end else begin
      zcheck_go          <= 1'b0;
      stim_finite_go     <= 1'b0;
      stim_infinite_go   <= 1'b0;
      stim_infinite_halt <= 1'b0;
      reject             <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (zcheck_start) begin
            state_q   <= S_ZCHECK;
            busy      <= 1'b1;
            zcheck_go <= 1'b1;
            reject    <= record_start | stim_start_any;
          end else if (record_start) begin
            state_q   <= S_REC_SETTLE;
            busy      <= 1'b1;
            record_en <= 1'b1;
            reject    <= stim_start_any;
          end else begin
            reject    <= stim_start_any;
          end
        end
        S_ZCHECK: begin
          reject <= any_start;
          if (zcheck_done) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        S_REC_SETTLE: begin
          reject <= any_start;
          if (record_stop) begin
            state_q   <= S_IDLE;
            busy      <= 1'b0;
            record_en <= 1'b0;
          end else if (settle_expired) begin
            state_q <= S_RECORD;
          end
        end
        S_RECORD: begin
          // A stop outranks any stim start arriving alongside it.
          if (record_stop) begin
            state_q   <= S_IDLE;
            busy      <= 1'b0;
            record_en <= 1'b0;
            reject    <= any_start;
          end else if (stim_finite_start) begin
            state_q        <= S_STIM;
            stim_finite_go <= 1'b1;
            inf_q          <= 1'b0;
            reject         <= stim_infinite_start | zcheck_start | record_start;
          end else if (stim_infinite_start) begin
            state_q          <= S_STIM;
            stim_infinite_go <= 1'b1;
            inf_q            <= 1'b1;
            reject           <= zcheck_start | record_start;
          end else begin
            reject <= zcheck_start | record_start;
          end
        end
        S_STIM: begin
          reject <= any_start;
          if (halt_now) begin
            stim_infinite_halt <= 1'b1;
            halt_sent_q        <= 1'b1;
          end
          if (record_stop) begin
            stop_pend_q <= 1'b1;
          end
          // The link is only released once the engine reports it is idle.
          if (stim_done) begin
            inf_q       <= 1'b0;
            halt_sent_q <= 1'b0;
            stop_pend_q <= 1'b0;
            if (stop_pend_q || record_stop) begin
              state_q   <= S_IDLE;
              busy      <= 1'b0;
              record_en <= 1'b0;
            end else begin
              state_q <= S_RECORD;
            end
          end
        end
        default: begin
          state_q   <= S_IDLE;
          busy      <= 1'b0;
          record_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seeg_mode_scheduler.sv
// Scoreboard bench for seeg_mode_scheduler: a rule-level model predicts every
// cycle's outputs, and an independent monitor compares them against the DUT.
module tb_seeg_mode_scheduler;

  localparam int SETTLE = 4;

  localparam logic [7:0] C_RS    = 8'h01;
  localparam logic [7:0] C_RSTOP = 8'h02;
  localparam logic [7:0] C_ZS    = 8'h04;
  localparam logic [7:0] C_FS    = 8'h08;
  localparam logic [7:0] C_IS    = 8'h10;
  localparam logic [7:0] C_ISTOP = 8'h20;
  localparam logic [7:0] C_ZDONE = 8'h40;
  localparam logic [7:0] C_SDONE = 8'h80;

  typedef struct packed {
    logic [2:0] st;
    logic       rec_en;
    logic       zgo;
    logic       fgo;
    logic       igo;
    logic       halt;
    logic       rej;
    logic       busy;
  } exp_t;

  logic       clk;
  logic       rstn;
  logic       record_start, record_stop, zcheck_start;
  logic       stim_finite_start, stim_infinite_start, stim_infinite_stop;
  logic       zcheck_done, stim_done;
  logic       record_en, zcheck_go, stim_finite_go, stim_infinite_go;
  logic       stim_infinite_halt, reject, busy;
  logic [2:0] state;

  int   tests_run;
  int   tests_failed;
  exp_t exp_q[$];

  // Model: mode 0 idle, 1 zcheck, 2 settling, 3 recording, 4 stimulating.
  int   m_mode;
  int   m_elapsed;
  bit   m_inf;
  bit   m_halt_sent;
  bit   m_stop_pend;

  seeg_mode_scheduler #(.SETTLE_CYCLES(SETTLE), .CNT_W(16)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .record_start        (record_start),
    .record_stop         (record_stop),
    .zcheck_start        (zcheck_start),
    .stim_finite_start   (stim_finite_start),
    .stim_infinite_start (stim_infinite_start),
    .stim_infinite_stop  (stim_infinite_stop),
    .zcheck_done         (zcheck_done),
    .stim_done           (stim_done),
    .record_en           (record_en),
    .zcheck_go           (zcheck_go),
    .stim_finite_go      (stim_finite_go),
    .stim_infinite_go    (stim_infinite_go),
    .stim_infinite_halt  (stim_infinite_halt),
    .reject              (reject),
    .busy                (busy),
    .state               (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmpField(input string name, input int act, input int expv);
    tests_run++;
    if (act != expv) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmpField("state", int'(state), int'(e.st));
    cmpField("record_en", int'(record_en), int'(e.rec_en));
    cmpField("busy", int'(busy), int'(e.busy));
    cmpField("zcheck_go", int'(zcheck_go), int'(e.zgo));
    cmpField("stim_finite_go", int'(stim_finite_go), int'(e.fgo));
    cmpField("stim_infinite_go", int'(stim_infinite_go), int'(e.igo));
    cmpField("stim_infinite_halt", int'(stim_infinite_halt), int'(e.halt));
    cmpField("reject", int'(reject), int'(e.rej));
  endtask

  task automatic modelReset();
    m_mode      = 0;
    m_elapsed   = 0;
    m_inf       = 1'b0;
    m_halt_sent = 1'b0;
    m_stop_pend = 1'b0;
  endtask

  // Applies the scheduling rules for one sampled cycle of host/engine inputs.
  task automatic modelStep(input logic [7:0] c, output exp_t e);
    bit rs, rstop, zs, fs, is_, istop, zd, sd, any;
    rs = c[0]; rstop = c[1]; zs = c[2]; fs = c[3];
    is_ = c[4]; istop = c[5]; zd = c[6]; sd = c[7];
    any = rs | zs | fs | is_;
    e = '0;
    case (m_mode)
      0: begin
        if (zs) begin
          m_mode = 1; e.zgo = 1'b1; e.rej = rs | fs | is_;
        end else if (rs) begin
          m_mode = 2; m_elapsed = 0; e.rej = fs | is_;
        end else begin
          e.rej = fs | is_;
        end
      end
      1: begin
        e.rej = any;
        if (zd) m_mode = 0;
      end
      2: begin
        e.rej = any;
        if (rstop) m_mode = 0;
        else begin
          m_elapsed++;
          if (m_elapsed >= ((SETTLE < 1) ? 1 : SETTLE)) m_mode = 3;
        end
      end
      3: begin
        if (rstop) begin
          m_mode = 0; e.rej = any;
        end else if (fs) begin
          m_mode = 4; m_inf = 1'b0; e.fgo = 1'b1; e.rej = is_ | zs | rs;
        end else if (is_) begin
          m_mode = 4; m_inf = 1'b1; e.igo = 1'b1; e.rej = zs | rs;
        end else begin
          e.rej = zs | rs;
        end
      end
      default: begin
        e.rej = any;
        if ((istop || rstop) && m_inf && !m_halt_sent) begin
          e.halt = 1'b1; m_halt_sent = 1'b1;
        end
        if (rstop) m_stop_pend = 1'b1;
        if (sd) begin
          m_mode = m_stop_pend ? 0 : 3;
          m_inf = 1'b0; m_halt_sent = 1'b0; m_stop_pend = 1'b0;
        end
      end
    endcase
    e.st     = 3'(m_mode);
    e.rec_en = (m_mode >= 2);
    e.busy   = (m_mode != 0);
  endtask

  task automatic applyStimulus(input logic [7:0] c);
    exp_t e;
    @(negedge clk);
    record_start        = c[0];
    record_stop         = c[1];
    zcheck_start        = c[2];
    stim_finite_start   = c[3];
    stim_infinite_start = c[4];
    stim_infinite_stop  = c[5];
    zcheck_done         = c[6];
    stim_done           = c[7];
    modelStep(c, e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(8'h00);
  endtask

  task automatic checkAllZero(input string tag);
    cmpField({tag, "_state"}, int'(state), 0);
    cmpField({tag, "_record_en"}, int'(record_en), 0);
    cmpField({tag, "_busy"}, int'(busy), 0);
    cmpField({tag, "_pulses"},
             int'({zcheck_go, stim_finite_go, stim_infinite_go, stim_infinite_halt, reject}), 0);
  endtask

  task automatic resetDut();
    @(negedge clk);
    {record_start, record_stop, zcheck_start, stim_finite_start} = '0;
    {stim_infinite_start, stim_infinite_stop, zcheck_done, stim_done} = '0;
    rstn = 1'b0;
    #1;
    checkAllZero("reset");
    repeat (2) @(negedge clk);
    exp_q.delete();
    modelReset();
    rstn = 1'b1;
  endtask

  // Monitor: compares each DUT output snapshot against the oldest prediction.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (rstn && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rstn         = 1'b0;
    modelReset();
    resetDut();

    // Settle, then finite stim returning to RECORD.
    applyStimulus(C_RS);
    idle(6);
    applyStimulus(C_FS);
    idle(3);
    applyStimulus(C_SDONE);
    idle(2);

    // Infinite stim ended by record_stop; repeated stops give no second halt.
    applyStimulus(C_IS);
    idle(2);
    applyStimulus(C_RSTOP);
    idle(4);
    applyStimulus(C_ISTOP);
    idle(14);
    applyStimulus(C_SDONE);
    idle(1);
    applyStimulus(C_ISTOP);
    idle(1);

    // Zcheck lockout.
    applyStimulus(C_ZS | C_RS);
    idle(1);
    applyStimulus(C_RS);
    applyStimulus(C_ZDONE);
    idle(1);

    // Illegal stim starts, both-stim conflict, stop racing a start.
    applyStimulus(C_IS);
    applyStimulus(C_RS);
    applyStimulus(C_IS);
    idle(5);
    applyStimulus(C_FS | C_IS);
    applyStimulus(C_SDONE);
    applyStimulus(C_RSTOP | C_IS);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] c;
      c = '0;
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 9) == 0) c[b] = 1'b1;
      end
      if (b_rs_boost(i)) c[0] = 1'b1;
      applyStimulus(c);
    end
    idle(2);

    // Reset asserted while stimulating.
    resetDut();
    applyStimulus(C_RS);
    idle(5);
    applyStimulus(C_IS);
    idle(3);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checkAllZero("midstim_reset");
    exp_q.delete();
    modelReset();
    @(negedge clk);
    rstn = 1'b1;
    idle(3);

    begin
      int waited;
      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
        @(posedge clk);
        waited++;
      end
      #2;
      tests_run++;
      if (exp_q.size() != 0) begin
        tests_failed++;
        $display("[TB] FAIL drain: %0d predictions left, expected 0", exp_q.size());
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Periodically re-arms recording so the random phase reaches STIM often.
  function automatic bit b_rs_boost(input int i);
    return (i % 37) == 0;
  endfunction

endmodule
